seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display, replacing the fixed 8-anode rotator with a parametrised scanner. It owns digit rotation, hex-to-segment decoding, decimal points, a per-digit enable mask, 16-level PWM brightness and tear-free frame-synchronous updates. It sits between game-state logic (score and length readout) and the top-level AN/SEG/DP pins.

## Interface
- N_DIGITS, 8, number of scanned digits (1..8); anode bits [7:N_DIGITS] are held inactive.
- REFRESH_TICKS, 100000, clk cycles per digit slot; must be ≥16.
- ACTIVE_LOW, 1, polarity of AN_o/SEG_o/DP_o; 1 means a 0 lights the segment.

- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- digits_i  in  4*N_DIGITS  hex nibble per digit; digit k = digits_i[4k+3:4k], digit 0 rightmost.
- dp_i  in  N_DIGITS  decimal point per digit, 1 = lit.
- en_i  in  N_DIGITS  digit enable mask, 0 = digit dark.
- brightness_i  in  4  duty level 0..15.
- load_i  in  1  single-cycle strobe; captures digits_i/dp_i/en_i into a pending buffer.
- AN_o  out  8  anode drives.
- SEG_o  out  7  segments, SEG_o[0]=a … SEG_o[6]=g.
- DP_o  out  1  decimal point drive.
- frame_o  out  1  one-cycle pulse at each frame start.

## Operation
- Slot counter ctr counts 0..REFRESH_TICKS-1; digit index idx advances when ctr wraps, N_DIGITS-1 → 0.
- Pending buffer: every load_i overwrites it; the last load in a frame wins. A pending flag records unconsumed loads.
- Commit: on the wrap edge (idx=N_DIGITS-1, ctr=REFRESH_TICKS-1), if pending is set, the buffer is copied to the display registers and the flag cleared. A load_i on that same edge bypasses straight into the display registers.
- brightness_i is sampled at every slot start (ctr=0).
- Decode: standard hex font 0-F. Active-low values: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
- Digit lit in slot idx when en[idx]=1 and 1 ≤ ctr < threshold.
  - threshold = (b+1)*(REFRESH_TICKS/16) for b<15, using integer division.
  - threshold = REFRESH_TICKS for b=15.
  - ctr=0 is always dark as an anti-ghosting guard.
- When lit: AN_o has only bit idx active, SEG_o = decode(digit[idx]), DP_o = dp[idx]. Otherwise AN_o, SEG_o and DP_o are all inactive.
- ACTIVE_LOW=0 inverts all three outputs.

## Timing
- Outputs are registered: AN_o/SEG_o/DP_o reflect the (idx, ctr) of the previous cycle, a 1-cycle latency.
- Frame period = N_DIGITS*REFRESH_TICKS cycles.
- frame_o is high for exactly the cycle after each wrap edge.
- Committed data first appears in slot 0, 2 cycles after the wrap edge, because of the ctr=0 guard.
- Reset values:
  - ctr=0, idx=0, pending=0.
  - Display digits=0, dp=0, en=0, brightness=15.
  - AN_o=8'hFF, SEG_o=7'h7F, DP_o=1, frame_o=0 (ACTIVE_LOW=1).
- The display is blank after reset until the first commit.
- Reset mid-slot or mid-frame aborts the scan, discards pending data and restores reset values on the next edge. It takes priority over load_i.
- N_DIGITS=1: idx stays 0 and every slot wrap is a frame wrap.

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero blanking is applied at commit. Every enabled digit above the most significant nonzero digit is forced dark. Digit 0 is never blanked. DP on a blanked digit is also suppressed.
- Undefined: zeros display normally and the mask is used as loaded.

## Test plan
- Reset, then hold rst 5 cycles mid-slot during active display → AN_o=FF, SEG_o=7F, DP_o=1, frame_o=0 from the edge after rst.
- REFRESH_TICKS=16, load digits 0x12345678, en=FF, b=15 → after commit: AN_o=FE with SEG_o=0000000 (8), then FD with 1111000 (7) … 7F with 1111001 (1). Frame period 128 cycles, frame_o every 128.
- REFRESH_TICKS=160, b=7 → anode active for ctr 1..79 (79 cycles) per slot. b=0 → ctr 1..9. b=15 → ctr 1..159.
- Load 0xAAAAAAAA mid-frame, then 0x00000001 later in the same frame → display unchanged until the wrap. Next frame shows only 0x00000001. A load exactly on the wrap edge commits in that same frame.
- N_DIGITS=4 → AN_o cycles FE, FD, FB, F7 and AN_o[7:4] stays 1 throughout.
- digits 0x00000305, en=FF, with SEG_LZ_BLANK_EN → digits 7..3 dark, digit 2 shows 3, digit 1 shows 0. Without the macro → digits 7..3 show 1000000.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//
// Time-multiplexed driver for an up-to-8-digit common-anode seven-segment
// display. It rotates through the digits, decodes hex nibbles, drives the
// decimal points and applies a per-digit enable mask. Brightness is 16-level
// PWM within each digit slot. New data is committed only at frame
// boundaries, so a frame never shows a mix of old and new values.
//
// Parameters:
//   N_DIGITS      - number of scanned digits (1..8); unused anodes stay off
//   REFRESH_TICKS - clk cycles per digit slot (>= 16)
//   ACTIVE_LOW    - 1: a 0 on AN_o/SEG_o/DP_o lights the element
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   digits_i      - hex nibble per digit, digit 0 in bits [3:0] (rightmost)
//   dp_i          - decimal point per digit, 1 = lit
//   en_i          - digit enable mask, 0 = digit dark
//   brightness_i  - PWM duty level 0..15, sampled at each slot start
//   load_i        - strobe capturing digits_i/dp_i/en_i into the pending buffer
//   AN_o          - anode drives
//   SEG_o         - segments, SEG_o[0]=a .. SEG_o[6]=g
//   DP_o          - decimal point drive
//   frame_o       - one-cycle pulse at each frame start
//
// Build option:
//   SEG_LZ_BLANK_EN - when defined, leading zeros are blanked at commit time
//                     (digit 0 is never blanked).

module seven_seg_scanner #(
  parameter int N_DIGITS      = 8,
  parameter int REFRESH_TICKS = 100000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   en_i,
  input  logic [3:0]            brightness_i,
  input  logic                  load_i,
  output logic [7:0]            AN_o,
  output logic [6:0]            SEG_o,
  output logic                  DP_o,
  output logic                  frame_o
);

  localparam int              CW       = $clog2(REFRESH_TICKS);
  localparam logic [CW-1:0]   CTR_LAST = CW'(REFRESH_TICKS - 1);
  localparam logic [2:0]      IDX_LAST = 3'(N_DIGITS - 1);
  localparam logic [31:0]     STEP     = 32'(REFRESH_TICKS / 16);
  localparam logic [7:0]      AN_OFF   = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0]      SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF   = ACTIVE_LOW;

  // Hex font, returned in active-low form (0 = segment on), bit 0 = a.
  function automatic logic [6:0] font(input logic [3:0] nib);
    case (nib)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  logic [CW-1:0]         ctr_q, ctr_d;
  logic [2:0]            idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_digits_q, pend_digits_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                  pending_q, pending_d;
  logic [4*N_DIGITS-1:0] disp_digits_q, disp_digits_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0]   disp_en_q, disp_en_d;
  logic [3:0]            bright_q, bright_d;
  logic [7:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  slot_end, wrap;
  logic [4*N_DIGITS-1:0] commit_digits;
  logic [N_DIGITS-1:0]   commit_dp, commit_en, blanked_en;
  logic [31:0]           thr, dig_all;
  logic [7:0]            en_all, dp_all, an_on;
  logic [6:0]            seg_on;
  logic                  lit, dp_on;
`ifdef SEG_LZ_BLANK_EN
  logic                  seen_nz;
`endif

  // Slot/digit scan position.
  always_comb begin
    slot_end = (ctr_q == CTR_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);
    ctr_d    = slot_end ? '0 : ctr_q + CW'(1);
    idx_d    = idx_q;
    if (slot_end) idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    frame_d  = wrap;
  end

  // A load on the wrap edge bypasses the pending buffer so it lands in the
  // frame that is just starting.
  always_comb begin
    commit_digits = load_i ? digits_i : pend_digits_q;
    commit_dp     = load_i ? dp_i     : pend_dp_q;
    commit_en     = load_i ? en_i     : pend_en_q;
    blanked_en    = commit_en;
`ifdef SEG_LZ_BLANK_EN
    // Walk down from the top digit, darkening zeros until the first nonzero.
    seen_nz = 1'b0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (commit_digits[4*k +: 4] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz) blanked_en[k] = 1'b0;
    end
`endif
  end

  // Pending buffer and frame-synchronous commit.
  always_comb begin
    disp_digits_d = disp_digits_q;
    disp_dp_d     = disp_dp_q;
    disp_en_d     = disp_en_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_en_d     = pend_en_q;
    pending_d     = pending_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (load_i || pending_q) begin
        disp_digits_d = commit_digits;
        disp_dp_d     = commit_dp;
        disp_en_d     = blanked_en;
      end
    end else if (load_i) begin
      pend_digits_d = digits_i;
      pend_dp_d     = dp_i;
      pend_en_d     = en_i;
      pending_d     = 1'b1;
    end
    bright_d = (ctr_q == '0) ? brightness_i : bright_q;
  end

  // PWM window and output decode. ctr=0 is always dark so the previous
  // digit's segments never ghost onto the newly selected anode.
  always_comb begin
    thr     = (bright_q == 4'hF) ? 32'(REFRESH_TICKS)
                                 : (32'(bright_q) + 32'd1) * STEP;
    dig_all = 32'(disp_digits_q);
    en_all  = 8'(disp_en_q);
    dp_all  = 8'(disp_dp_q);
    lit     = en_all[idx_q] && (ctr_q != '0) && (32'(ctr_q) < thr);
    an_on   = lit ? (8'd1 << idx_q) : 8'd0;
    seg_on  = lit ? ~font(dig_all[{idx_q, 2'b00} +: 4]) : 7'd0;
    dp_on   = lit && dp_all[idx_q];
    an_d    = ACTIVE_LOW ? ~an_on  : an_on;
    seg_d   = ACTIVE_LOW ? ~seg_on : seg_on;
    dp_d    = ACTIVE_LOW ? ~dp_on  : dp_on;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q         <= '0;
      idx_q         <= 3'd0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      pending_q     <= 1'b0;
      disp_digits_q <= '0;
      disp_dp_q     <= '0;
      disp_en_q     <= '0;
      bright_q      <= 4'hF;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      frame_q       <= 1'b0;
    end else begin
      ctr_q         <= ctr_d;
      idx_q         <= idx_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      pending_q     <= pending_d;
      disp_digits_q <= disp_digits_d;
      disp_dp_q     <= disp_dp_d;
      disp_en_q     <= disp_en_d;
      bright_q      <= bright_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_q       <= frame_d;
    end
  end

  assign AN_o    = an_q;
  assign SEG_o   = seg_q;
  assign DP_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Testbench for seven_seg_scanner. Two instances run side by side:
// an 8-digit scanner with 16-cycle slots and a 4-digit scanner with
// 160-cycle slots. A cycle-level behavioural model predicts each instance's
// outputs; predictions are queued when a cycle's stimulus is driven and
// popped and compared once the DUT has clocked that cycle.
module tb_seven_seg_scanner;

  localparam int N0 = 8, RT0 = 16;
  localparam int N1 = 4, RT1 = 160;
`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif
  localparam logic [16:0] OUT_OFF = {8'hFF, 7'h7F, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] digits_i;
  logic [7:0]  dp_i, en_i;
  logic [3:0]  brightness_i;
  logic        load_i;

  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dpo0, dpo1, fr0, fr1;

  int total = 0;
  int bad   = 0;

  logic [16:0] sb[$];

  // Active-low hex font, bit 0 = segment a.
  logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state per instance: scan position within the frame, displayed data,
  // next-frame data and the brightness latched at the last slot start.
  int          m_pos  [2];
  logic [31:0] m_dig  [2];
  logic [7:0]  m_dp   [2];
  logic [7:0]  m_en   [2];
  logic [31:0] m_ndig [2];
  logic [7:0]  m_ndp  [2];
  logic [7:0]  m_nen  [2];
  logic [3:0]  m_b    [2];
  bit          m_has  [2];

  always #5 clk = ~clk;

  seven_seg_scanner #(.N_DIGITS(N0), .REFRESH_TICKS(RT0), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .digits_i(digits_i), .dp_i(dp_i), .en_i(en_i),
    .brightness_i(brightness_i), .load_i(load_i),
    .AN_o(an0), .SEG_o(seg0), .DP_o(dpo0), .frame_o(fr0));

  seven_seg_scanner #(.N_DIGITS(N1), .REFRESH_TICKS(RT1), .ACTIVE_LOW(1'b1)) dut4 (
    .clk(clk), .rst(rst), .digits_i(digits_i[15:0]), .dp_i(dp_i[3:0]), .en_i(en_i[3:0]),
    .brightness_i(brightness_i), .load_i(load_i),
    .AN_o(an1), .SEG_o(seg1), .DP_o(dpo1), .frame_o(fr1));

  function automatic int nd(int i);
    return (i != 0) ? N1 : N0;
  endfunction

  function automatic int rt(int i);
    return (i != 0) ? RT1 : RT0;
  endfunction

  function automatic logic [7:0] lzMask(logic [31:0] d, logic [7:0] e, int n);
    logic [7:0] r;
    r = e;
    for (int k = n - 1; k >= 1; k--) begin
      if (!LZ_ON || d[4*k +: 4] != 4'd0) break;
      r[k] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [16:0] modelOut(int i);
    int n, r, idx, c, thr;
    logic lit;
    logic [7:0] an;
    logic [6:0] sg;
    logic dp;
    n   = nd(i);
    r   = rt(i);
    idx = m_pos[i] / r;
    c   = m_pos[i] % r;
    thr = (m_b[i] == 4'hF) ? r : (int'(m_b[i]) + 1) * (r / 16);
    lit = m_en[i][idx] && (c >= 1) && (c < thr);
    an  = 8'hFF;
    sg  = 7'h7F;
    dp  = 1'b1;
    if (lit) begin
      an[idx] = 1'b0;
      sg      = FONT[m_dig[i][4*idx +: 4]];
      dp      = ~m_dp[i][idx];
    end
    return {an, sg, dp, (m_pos[i] == n * r - 1)};
  endfunction

  function automatic void modelAdvance(int i);
    int n, r;
    logic [31:0] d;
    logic [7:0] p, e;
    n = nd(i);
    r = rt(i);
    d = (i != 0) ? (digits_i & 32'h0000FFFF) : digits_i;
    p = (i != 0) ? (dp_i & 8'h0F) : dp_i;
    e = (i != 0) ? (en_i & 8'h0F) : en_i;
    if (rst) begin
      m_pos[i] = 0;
      m_dig[i] = '0;
      m_dp[i]  = '0;
      m_en[i]  = '0;
      m_b[i]   = 4'hF;
      m_has[i] = 1'b0;
      return;
    end
    if (m_pos[i] % r == 0) m_b[i] = brightness_i;
    if (m_pos[i] == n * r - 1) begin
      if (load_i) begin
        m_dig[i] = d;
        m_dp[i]  = p;
        m_en[i]  = lzMask(d, e, n);
      end else if (m_has[i]) begin
        m_dig[i] = m_ndig[i];
        m_dp[i]  = m_ndp[i];
        m_en[i]  = lzMask(m_ndig[i], m_nen[i], n);
      end
      m_has[i] = 1'b0;
    end else if (load_i) begin
      m_ndig[i] = d;
      m_ndp[i]  = p;
      m_nen[i]  = e;
      m_has[i]  = 1'b1;
    end
    m_pos[i] = (m_pos[i] + 1) % (n * r);
  endfunction

  task automatic checkOutput(string tag, logic [16:0] got, logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got {an,seg,dp,frame}=%h expected %h", tag, $time, got, exp);
    end
  endtask

  // One clock: queue both predictions, advance the model, then compare.
  task automatic tick(string tag);
    for (int i = 0; i < 2; i++) sb.push_back(rst ? OUT_OFF : modelOut(i));
    for (int i = 0; i < 2; i++) modelAdvance(i);
    @(posedge clk);
    #1;
    checkOutput({tag, "/d8"}, {an0, seg0, dpo0, fr0}, sb.pop_front());
    checkOutput({tag, "/d4"}, {an1, seg1, dpo1, fr1}, sb.pop_front());
  endtask

  task automatic run(int n, string tag);
    for (int c = 0; c < n; c++) tick(tag);
  endtask

  task automatic applyStimulus(logic [31:0] d, logic [7:0] p, logic [7:0] e,
                               logic [3:0] b, string tag);
    digits_i     = d;
    dp_i         = p;
    en_i         = e;
    brightness_i = b;
    load_i       = 1'b1;
    tick(tag);
    load_i       = 1'b0;
  endtask

  task automatic alignTo(int pos);
    for (int c = 0; c < N0 * RT0 && m_pos[0] != pos; c++) tick("align");
  endtask

  initial begin
    rst          = 1'b1;
    digits_i     = '0;
    dp_i         = '0;
    en_i         = '0;
    brightness_i = 4'hF;
    load_i       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_dig[i] = '0; m_dp[i] = '0; m_en[i] = '0;
      m_ndig[i] = '0; m_ndp[i] = '0; m_nen[i] = '0; m_b[i] = 4'hF; m_has[i] = 1'b0;
    end

    run(3, "reset");
    rst = 1'b0;
    run(20, "blank");

    applyStimulus(32'h12345678, 8'h81, 8'hFF, 4'hF, "load1");
    run(700, "full");

    brightness_i = 4'd7;
    run(700, "b7");
    brightness_i = 4'd0;
    run(700, "b0");
    brightness_i = 4'hF;

    alignTo(0);
    run(10, "pre");
    applyStimulus(32'hAAAAAAAA, 8'h00, 8'hFF, 4'hF, "loadA");
    run(20, "midA");
    applyStimulus(32'h00000001, 8'h00, 8'hFF, 4'hF, "load01");
    run(300, "last_wins");

    alignTo(N0 * RT0 - 1);
    applyStimulus(32'h00000305, 8'hFF, 8'hFF, 4'hF, "wrap_load");
    run(700, "lz");

    applyStimulus(32'h9ABCDEF0, 8'h3C, 8'hA5, 4'd11, "mask");
    run(200, "mask");
    applyStimulus(32'h00001111, 8'h00, 8'hFF, 4'hF, "pend");
    run(5, "pend");
    rst = 1'b1;
    run(5, "rst_mid");
    rst = 1'b0;
    run(300, "post_rst");

    for (int it = 0; it < 12; it++) begin
      logic [31:0] d;
      d = $urandom >> ($urandom_range(0, 7) * 4);
      applyStimulus(d, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), "rnd");
      run($urandom_range(1, 400), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
